// File: rtl/decode_stage_pipe.sv
// Pipelined Y86-64 decode stage: register-id decode, register file read with
// write-through, and a one-entry valid/ready output register. Optional macro: DECODE_FWD_EN.
module decode_stage_pipe #(
    parameter int              DW    = 64,
    parameter int              NREG  = 15,
    parameter int              RW    = 4,
    parameter logic [RW-1:0]   RNONE = {RW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_icode,
    input  logic [3:0]    in_ifun,
    input  logic [RW-1:0] in_rA,
    input  logic [RW-1:0] in_rB,
    input  logic [DW-1:0] in_valC,
    input  logic [DW-1:0] in_valP,
    input  logic          wb_e_en,
    input  logic [RW-1:0] wb_e_dst,
    input  logic [DW-1:0] wb_e_val,
    input  logic          wb_m_en,
    input  logic [RW-1:0] wb_m_dst,
    input  logic [DW-1:0] wb_m_val,
`ifdef DECODE_FWD_EN
    input  logic          ex_fwd_en,
    input  logic [RW-1:0] ex_fwd_dst,
    input  logic [DW-1:0] ex_fwd_val,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_icode,
    output logic [3:0]    out_ifun,
    output logic [DW-1:0] out_valA,
    output logic [DW-1:0] out_valB,
    output logic [DW-1:0] out_valC,
    output logic [DW-1:0] out_valP,
    output logic [RW-1:0] out_srcA,
    output logic [RW-1:0] out_srcB,
    output logic [RW-1:0] out_dstE,
    output logic [RW-1:0] out_dstM,
    output logic          out_instr_err
);

    localparam logic [RW-1:0] RSP = RW'(4);

    // Handshake: a bundle moves when valid and ready are both high at a posedge;
    // out_* stay stable while out_valid is high and out_ready is low.
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state;

    logic [DW-1:0] regs [NREG];

    logic [RW-1:0] d_srcA, d_srcB, d_dstE, d_dstM;
    logic          d_err;
    logic [DW-1:0] op_a, op_b;
    logic          capture;

    function automatic logic id_ok(input logic [RW-1:0] id);
        return int'(id) < NREG;
    endfunction

    assign out_valid = (state == FULL);
    assign in_ready  = (state == EMPTY) | out_ready;
    assign capture   = in_valid & in_ready;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        d_err  = (in_icode > 4'hB);
        case (in_icode)
            4'h2: begin d_srcA = in_rA; d_dstE = in_rB; end
            4'h3: begin d_dstE = in_rB; end
            4'h4: begin d_srcA = in_rA; d_srcB = in_rB; end
            4'h5: begin d_srcB = in_rB; d_dstM = in_rA; end
            4'h6: begin d_srcA = in_rA; d_srcB = in_rB; d_dstE = in_rB; end
            4'h8: begin d_srcB = RSP; d_dstE = RSP; end
            4'h9: begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
            4'hA: begin d_srcA = in_rA; d_srcB = RSP; d_dstE = RSP; end
            4'hB: begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = in_rA; end
            default: ;
        endcase
    end

    // Operand select: later assignments win, giving ex_fwd > wb_m > wb_e > array.
    always_comb begin
        op_a = '0;
        if (id_ok(d_srcA)) begin
            op_a = regs[d_srcA];
            if (wb_e_en && wb_e_dst == d_srcA) op_a = wb_e_val;
            if (wb_m_en && wb_m_dst == d_srcA) op_a = wb_m_val;
`ifdef DECODE_FWD_EN
            if (ex_fwd_en && ex_fwd_dst == d_srcA) op_a = ex_fwd_val;
`endif
        end
    end

    always_comb begin
        op_b = '0;
        if (id_ok(d_srcB)) begin
            op_b = regs[d_srcB];
            if (wb_e_en && wb_e_dst == d_srcB) op_b = wb_e_val;
            if (wb_m_en && wb_m_dst == d_srcB) op_b = wb_m_val;
`ifdef DECODE_FWD_EN
            if (ex_fwd_en && ex_fwd_dst == d_srcB) op_b = ex_fwd_val;
`endif
        end
    end

    // M is written after E so a same-cycle collision keeps the M value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wb_e_en && id_ok(wb_e_dst)) regs[wb_e_dst] <= wb_e_val;
            if (wb_m_en && id_ok(wb_m_dst)) regs[wb_m_dst] <= wb_m_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            out_icode     <= '0;
            out_ifun      <= '0;
            out_valA      <= '0;
            out_valB      <= '0;
            out_valC      <= '0;
            out_valP      <= '0;
            out_srcA      <= RNONE;
            out_srcB      <= RNONE;
            out_dstE      <= RNONE;
            out_dstM      <= RNONE;
            out_instr_err <= 1'b0;
        end else if (capture) begin
            state         <= FULL;
            out_icode     <= in_icode;
            out_ifun      <= in_ifun;
            out_valA      <= op_a;
            out_valB      <= op_b;
            out_valC      <= in_valC;
            out_valP      <= in_valP;
            out_srcA      <= d_srcA;
            out_srcB      <= d_srcB;
            out_dstE      <= d_dstE;
            out_dstM      <= d_dstM;
            out_instr_err <= d_err;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomized bench for decode_stage_pipe against a bundle-level reference model
// with an expected-bundle queue; honours DECODE_FWD_EN when defined.
module tb_decode_stage_pipe;
    localparam int DW = 64;
    localparam int NREG = 15;
    localparam int RW = 4;
    localparam logic [RW-1:0] RN = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_icode = '0, in_ifun = '0;
    logic [RW-1:0] in_rA = '0, in_rB = '0;
    logic [DW-1:0] in_valC = '0, in_valP = '0;
    logic          wb_e_en = 1'b0, wb_m_en = 1'b0;
    logic [RW-1:0] wb_e_dst = '0, wb_m_dst = '0;
    logic [DW-1:0] wb_e_val = '0, wb_m_val = '0;
`ifdef DECODE_FWD_EN
    logic          ex_fwd_en = 1'b0;
    logic [RW-1:0] ex_fwd_dst = '0;
    logic [DW-1:0] ex_fwd_val = '0;
`endif
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_icode, out_ifun;
    logic [DW-1:0] out_valA, out_valB, out_valC, out_valP;
    logic [RW-1:0] out_srcA, out_srcB, out_dstE, out_dstM;
    logic          out_instr_err;

    decode_stage_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC), .in_valP(in_valP),
        .wb_e_en(wb_e_en), .wb_e_dst(wb_e_dst), .wb_e_val(wb_e_val),
        .wb_m_en(wb_m_en), .wb_m_dst(wb_m_dst), .wb_m_val(wb_m_val),
`ifdef DECODE_FWD_EN
        .ex_fwd_en(ex_fwd_en), .ex_fwd_dst(ex_fwd_dst), .ex_fwd_val(ex_fwd_val),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_ifun(out_ifun),
        .out_valA(out_valA), .out_valB(out_valB), .out_valC(out_valC), .out_valP(out_valP),
        .out_srcA(out_srcA), .out_srcB(out_srcB), .out_dstE(out_dstE), .out_dstM(out_dstM),
        .out_instr_err(out_instr_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model
    typedef struct {
        logic [3:0]    icode, ifun;
        logic [DW-1:0] valA, valB, valC, valP;
        logic [RW-1:0] srcA, srcB, dstE, dstM;
        logic          err;
    } bundle_t;

    bundle_t       exp_q[$];
    logic [DW-1:0] mregs [16];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [RW-1:0] id);
        logic [DW-1:0] v;
        if (int'(id) >= NREG) return '0;
        v = mregs[id];
        if (wb_e_en && wb_e_dst == id) v = wb_e_val;
        if (wb_m_en && wb_m_dst == id) v = wb_m_val;
`ifdef DECODE_FWD_EN
        if (ex_fwd_en && ex_fwd_dst == id) v = ex_fwd_val;
`endif
        return v;
    endfunction

    function automatic bundle_t model_decode();
        bundle_t b;
        int ic;
        ic = int'(in_icode);
        b.icode = in_icode;
        b.ifun  = in_ifun;
        b.valC  = in_valC;
        b.valP  = in_valP;
        b.err   = (ic > 11);
        b.srcA  = (ic inside {2, 4, 6, 10}) ? in_rA : (ic inside {9, 11}) ? 4'd4 : RN;
        b.srcB  = (ic inside {4, 5, 6}) ? in_rB : (ic inside {8, 9, 10, 11}) ? 4'd4 : RN;
        b.dstE  = (ic inside {2, 3, 6}) ? in_rB : (ic inside {8, 9, 10, 11}) ? 4'd4 : RN;
        b.dstM  = (ic inside {5, 11}) ? in_rA : RN;
        b.valA  = model_read(b.srcA);
        b.valB  = model_read(b.srcB);
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        exp_q.delete();
    endtask

    // Called at a negedge with inputs settled: check outputs, advance the model, run one edge.
    task automatic step();
        bit ev, er;
        #1;
        ev = (exp_q.size() != 0);
        er = !ev || out_ready;
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, ev);
        if (ev) begin
            check("valA", out_valA, exp_q[0].valA);
            check("valB", out_valB, exp_q[0].valB);
            check("valC", out_valC, exp_q[0].valC);
            check("valP", out_valP, exp_q[0].valP);
            check("ids", {out_icode, out_ifun, out_srcA, out_srcB, out_dstE, out_dstM, out_instr_err},
                  {exp_q[0].icode, exp_q[0].ifun, exp_q[0].srcA, exp_q[0].srcB,
                   exp_q[0].dstE, exp_q[0].dstM, exp_q[0].err});
            if (out_ready) void'(exp_q.pop_front());
        end
        if (in_valid && er) exp_q.push_back(model_decode());
        if (wb_e_en && int'(wb_e_dst) < NREG) mregs[wb_e_dst] = wb_e_val;
        if (wb_m_en && int'(wb_m_dst) < NREG) mregs[wb_m_dst] = wb_m_val;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        wb_e_en  = 1'b0;
        wb_m_en  = 1'b0;
`ifdef DECODE_FWD_EN
        ex_fwd_en = 1'b0;
`endif
    endtask

    task automatic drive(input logic [3:0] ic, input logic [RW-1:0] ra, input logic [RW-1:0] rb);
        in_valid = 1'b1;
        in_icode = ic;
        in_ifun  = 4'($urandom_range(0, 15));
        in_rA    = ra;
        in_rB    = rb;
        in_valC  = {$urandom, $urandom};
        in_valP  = {$urandom, $urandom};
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ids", {out_srcA, out_srcB, out_dstE, out_dstM}, {RN, RN, RN, RN});
        check("rst_vals", out_valA | out_valB | out_valC | out_valP, 64'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        apply_reset();

        // 1: plain read after reset
        out_ready = 1'b1;
        drive(4'h6, 4'd2, 4'd3);
        step();
        idle_inputs();
        check("t1_valA", out_valA, 64'h0);
        check("t1_valB", out_valB, 64'h0);
        check("t1_dstE", out_dstE, 4'd3);
        step();

        // 2: write-through from wb_e in the capture cycle
        drive(4'h6, 4'd2, 4'd2);
        wb_e_en = 1'b1; wb_e_dst = 4'd2; wb_e_val = 64'h10;
        step();
        idle_inputs();
        check("t2_valA", out_valA, 64'h10);
        check("t2_valB", out_valB, 64'h10);
        step();

        // 3: E and M collide, M stored
        wb_e_en = 1'b1; wb_e_dst = 4'd5; wb_e_val = 64'h1;
        wb_m_en = 1'b1; wb_m_dst = 4'd5; wb_m_val = 64'h2;
        step();
        idle_inputs();
        drive(4'h2, 4'd5, 4'd7);
        step();
        idle_inputs();
        check("t3_valA", out_valA, 64'h2);
        step();

        // 4: pushq held under backpressure, regs change underneath
        wb_e_en = 1'b1; wb_e_dst = 4'd1; wb_e_val = 64'h7;
        wb_m_en = 1'b1; wb_m_dst = 4'd4; wb_m_val = 64'h100;
        step();
        idle_inputs();
        drive(4'hA, 4'd1, RN);
        step();
        idle_inputs();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_e_en = 1'b1; wb_e_dst = 4'd1; wb_e_val = 64'h99;
            #1;
            check("t4_in_ready", in_ready, 1'b0);
            check("t4_valA", out_valA, 64'h7);
            check("t4_valB", out_valB, 64'h100);
            check("t4_srcB_dstE", {out_srcB, out_dstE}, {4'd4, 4'd4});
            step();
        end
        idle_inputs();
        out_ready = 1'b1;
        step();
        check("t4_drained", out_valid, 1'b0);

        // 5: invalid icode, then async reset while FULL
        drive(4'hC, 4'd1, 4'd2);
        step();
        idle_inputs();
        out_ready = 1'b0;
        check("t5_err", out_instr_err, 1'b1);
        check("t5_ids", {out_srcA, out_srcB, out_dstE, out_dstM}, {RN, RN, RN, RN});
        apply_reset();
        out_ready = 1'b1;
        drive(4'h6, 4'd1, 4'd4);
        step();
        idle_inputs();
        check("t5_cleared", out_valA | out_valB, 64'h0);
        step();

`ifdef DECODE_FWD_EN
        // 6: ex forward beats wb_m, array receives wb_m only
        drive(4'h4, 4'd3, 4'd3);
        ex_fwd_en = 1'b1; ex_fwd_dst = 4'd3; ex_fwd_val = 64'hAA;
        wb_m_en = 1'b1; wb_m_dst = 4'd3; wb_m_val = 64'hBB;
        step();
        idle_inputs();
        check("t6_valA", out_valA, 64'hAA);
        drive(4'h4, 4'd3, 4'd3);
        step();
        idle_inputs();
        check("t6_array", out_valA, 64'hBB);
        step();
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle_inputs();
            if ($urandom_range(0, 9) < 7)
                drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 1) begin
                wb_e_en = 1'b1; wb_e_dst = 4'($urandom_range(0, 15)); wb_e_val = {$urandom, $urandom};
            end
            if ($urandom_range(0, 1) == 1) begin
                wb_m_en = 1'b1; wb_m_dst = 4'($urandom_range(0, 15)); wb_m_val = {$urandom, $urandom};
            end
`ifdef DECODE_FWD_EN
            if ($urandom_range(0, 2) == 0) begin
                ex_fwd_en = 1'b1; ex_fwd_dst = 4'($urandom_range(0, 15)); ex_fwd_val = {$urandom, $urandom};
            end
`endif
            if (c == 1500) begin
                apply_reset();
            end else begin
                step();
            end
        end

        idle_inputs();
        out_ready = 1'b1;
        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
